fifo_fwft_sink: RTL and testbench

Synthesizable read-side traffic sink for first-word-fall-through FIFOs, used in FIFO benches and on-chip self-test. Once started it drains a programmable number of words from a FWFT FIFO. Read attempts are throttled by an LFSR against a programmable rate threshold. An inactivity watchdog aborts stalled blocks, and an optional checker compares read data against an incrementing reference pattern.

---
 rtl/fifo_fwft_sink_if.sv | 12 +
 rtl/fifo_fwft_sink.sv | 168 ++++++++++++++++
 tb/tb_fifo_fwft_sink.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_fwft_sink_if.sv
// FWFT FIFO read port: head word, empty flag, read strobe.
// master = the reader (sink), slave = the FIFO.
interface fifo_fwft_sink_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             empty;
  logic             rden;

  modport master (input din, input empty, output rden);
  modport slave  (output din, output empty, input rden);
endinterface

// File: rtl/fifo_fwft_sink.sv
// fifo_fwft_sink: drains a programmed number of words from a FWFT FIFO.
// Reads are throttled by a 16-bit Galois LFSR compared against a rate
// threshold, an inactivity watchdog aborts stalled blocks.
// Optional data checker: define FIFO_FWFT_SINK_CHECK_EN to compare read data
// against an incrementing pattern starting at expect_base.
module fifo_fwft_sink #(
  parameter int          WIDTH     = 8,
  parameter int          LEN_W     = 16,
  parameter int          RATE_W    = 8,
  parameter int          TIMEOUT_W = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fifo_fwft_sink_if.master     fifo,
  input  logic                 start,
  input  logic [LEN_W-1:0]     length,
  input  logic [RATE_W-1:0]    rate,
  input  logic [TIMEOUT_W-1:0] timeout,
  input  logic [WIDTH-1:0]     expect_base,
  output logic                 busy,
  output logic                 done,
  output logic [LEN_W-1:0]     word_count,
  output logic [WIDTH-1:0]     last_data,
  output logic                 err_timeout,
  output logic                 err_data,
  output logic [7:0]           err_count
);

  typedef enum logic {IDLE, READ} state_t;

  state_t               state_q, state_d;
  logic [15:0]          lfsr_q;
  logic [LEN_W-1:0]     len_q;
  logic [RATE_W-1:0]    rate_q;
  logic [TIMEOUT_W-1:0] to_q;
  logic [TIMEOUT_W-1:0] idle_q;

  logic thr_ok, xfer, last_word, wd_hit;
  logic load, zstart, fin, abort;

  assign busy      = (state_q == READ);
  // All-ones rate bypasses the LFSR so full throughput is reachable.
  assign thr_ok    = (&rate_q) | (lfsr_q[RATE_W-1:0] < rate_q);
  assign fifo.rden = busy & thr_ok & ~fifo.empty;
  assign xfer      = fifo.rden;
  assign last_word = (word_count + LEN_W'(1)) == len_q;
  // Watchdog fires only on a stall cycle; a transfer on the same edge wins.
  assign wd_hit    = (to_q != '0) & ~xfer & (idle_q == to_q - TIMEOUT_W'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and block-control strobes
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    zstart  = 1'b0;
    fin     = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            load    = 1'b1;
            state_d = READ;
          end else begin
            zstart  = 1'b1;
          end
        end
      end
      READ: begin
        if (xfer && last_word) begin
          fin     = 1'b1;
          state_d = IDLE;
        end else if (wd_hit) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Throttle LFSR: x^16+x^14+x^13+x^11+1, steps only while a block runs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    lfsr_q <= LFSR_SEED;
    else if (busy) lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  // Block parameters captured at start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q  <= '0;
      rate_q <= '0;
      to_q   <= '0;
    end else if (load) begin
      len_q  <= length;
      rate_q <= rate;
      to_q   <= timeout;
    end
  end

  // Transfer bookkeeping and inactivity counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count <= '0;
      last_data  <= '0;
      idle_q     <= '0;
    end else if (load || zstart) begin
      word_count <= '0;
      idle_q     <= '0;
    end else if (xfer) begin
      word_count <= word_count + LEN_W'(1);
      last_data  <= fifo.din;
      idle_q     <= '0;
    end else if (busy) begin
      idle_q     <= idle_q + TIMEOUT_W'(1);
    end
  end

  // Completion pulse and watchdog flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      done <= fin | abort | zstart;
      if (load || zstart) err_timeout <= 1'b0;
      else if (abort)     err_timeout <= 1'b1;
    end
  end

`ifdef FIFO_FWFT_SINK_CHECK_EN
  logic [WIDTH-1:0] exp_q;
  logic             miss;

  assign miss = xfer & (fifo.din != exp_q);

  // Reference pattern and sticky mismatch tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q     <= '0;
      err_data  <= 1'b0;
      err_count <= '0;
    end else if (load || zstart) begin
      exp_q     <= expect_base;
      err_data  <= 1'b0;
      err_count <= '0;
    end else begin
      if (xfer) exp_q <= exp_q + WIDTH'(1);
      if (miss) begin
        err_data <= 1'b1;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end
`else
  logic unused_expect_base;
  assign unused_expect_base = ^expect_base;
  assign err_data  = 1'b0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_fifo_fwft_sink.sv
// Scoreboard bench for fifo_fwft_sink: behavioural FIFO, block-level
// reference model, negedge monitor comparing every output each cycle.
module tb_fifo_fwft_sink;
  localparam int          WIDTH = 8, LEN_W = 16, RATE_W = 8, TIMEOUT_W = 16;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 start = 1'b0;
  logic [LEN_W-1:0]     length = '0;
  logic [RATE_W-1:0]    rate = '0;
  logic [TIMEOUT_W-1:0] timeout = '0;
  logic [WIDTH-1:0]     expect_base = '0;
  logic                 busy, done, err_timeout, err_data;
  logic [LEN_W-1:0]     word_count;
  logic [WIDTH-1:0]     last_data;
  logic [7:0]           err_count;

  fifo_fwft_sink_if #(.WIDTH(WIDTH)) fif ();

  fifo_fwft_sink #(.WIDTH(WIDTH), .LEN_W(LEN_W), .RATE_W(RATE_W),
                   .TIMEOUT_W(TIMEOUT_W), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .fifo(fif), .start(start), .length(length),
    .rate(rate), .timeout(timeout), .expect_base(expect_base), .busy(busy),
    .done(done), .word_count(word_count), .last_data(last_data),
    .err_timeout(err_timeout), .err_data(err_data), .err_count(err_count));

  int n_chk = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural FWFT FIFO
  logic [WIDTH-1:0] mem [0:4095];
  logic [11:0]      wr_ptr = '0, rd_ptr = '0;
  logic [WIDTH-1:0] exp_q[$];   // words in the order the sink must read them
  logic [WIDTH-1:0] pend[$];    // words still to be trickled into the FIFO
  assign fif.din   = mem[rd_ptr];
  assign fif.empty = (wr_ptr == rd_ptr);
  always @(posedge clk) if (fif.rden) rd_ptr <= rd_ptr + 12'd1;

  task automatic push(input logic [WIDTH-1:0] w);
    mem[wr_ptr] = w;
    exp_q.push_back(w);
    wr_ptr = wr_ptr + 12'd1;
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // Reference model state
  bit               m_busy, m_done, m_to, m_errd, m_rd;
  int               m_cnt, m_len, m_tmo, m_idle, m_errc;
  logic [15:0]      m_lfsr = SEED;
  logic [RATE_W-1:0] m_rate;
  logic [WIDTH-1:0] m_last, m_exp;

  // Model: advances one clock at a time from the block-level rules
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_to = 0; m_errd = 0; m_errc = 0;
      m_cnt = 0; m_idle = 0; m_lfsr = SEED; m_last = '0; m_rd = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        if (m_rd) begin
          logic [WIDTH-1:0] w;
          w = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
          m_last = w;
`ifdef FIFO_FWFT_SINK_CHECK_EN
          if (w != m_exp) begin m_errd = 1; if (m_errc < 255) m_errc++; end
          m_exp = m_exp + 1'b1;
`endif
          m_cnt++; m_idle = 0;
          if (m_cnt == m_len) begin m_busy = 0; m_done = 1; end
        end else if (m_tmo != 0) begin
          if (m_idle == m_tmo - 1) begin m_busy = 0; m_done = 1; m_to = 1; end
          else m_idle++;
        end
        m_lfsr = lfsr_next(m_lfsr);
      end else if (start) begin
        m_cnt = 0; m_to = 0; m_errd = 0; m_errc = 0; m_idle = 0;
        if (length != 0) begin
          m_busy = 1; m_len = int'(length); m_rate = rate;
          m_tmo = int'(timeout); m_exp = expect_base;
        end else m_done = 1;
      end
    end
  end

  // Monitor: compares every output, and the head word on each expected read
  always @(negedge clk) begin
    m_rd = m_busy && !fif.empty && ((&m_rate) || (m_lfsr[RATE_W-1:0] < m_rate));
    chk("rden", fif.rden, m_rd);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("word_count", word_count, m_cnt);
    chk("last_data", last_data, m_last);
    chk("err_timeout", err_timeout, m_to);
    chk("err_data", err_data, m_errd);
    chk("err_count", err_count, m_errc);
    if (m_rd) begin
      if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
      else                   chk("read_data", fif.din, exp_q[0]);
    end
  end

  task automatic do_start(input int len, input int rt, input int tmo, input int base);
    start = 1'b1; length = LEN_W'(len); rate = RATE_W'(rt);
    timeout = TIMEOUT_W'(tmo); expect_base = WIDTH'(base);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns at negedge+1 of the done cycle; cycles counted from the start edge
  task automatic wait_done(input int maxc, output int cycles);
    int c0, n;
    c0 = cyc; n = 0;
    @(negedge clk);
    while (!done && n < maxc) begin
      #1;
      if (pend.size() != 0 && $urandom_range(0, 1) == 1) push(pend.pop_front());
      @(negedge clk);
      n++;
    end
    cycles = cyc - c0;
    n_chk++;
    if (!done) begin
      n_fail++;
      $display("FAIL done_wait: no done after %0d cycles", maxc);
    end
    #1;
  endtask

  initial begin
    int cy;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);    chk("rst_done", done, 0);
    chk("rst_rden", fif.rden, 0); chk("rst_wc", word_count, 0);
    rst_n = 1'b1;

    // Full-rate block of 4
    for (int i = 0; i < 4; i++) push(WIDTH'(8'h10 + i));
    do_start(4, 8'hFF, 0, 8'h10);
    wait_done(100, cy);
    chk("full_rate_cycles", cy, 4);
    chk("t1_last", last_data, 8'h13);
    chk("t1_errd", err_data, 0);

    // rate=0 watchdog abort after 20 cycles
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) push(WIDTH'(8'hA0 + i));
    do_start(3, 0, 20, 0);
    wait_done(100, cy);
    chk("timeout_cycles", cy, 20);
    chk("t2_err_timeout", err_timeout, 1);
    chk("t2_wc", word_count, 0);
    do_start(3, 8'hFF, 0, 8'hA0);          // drain the three parked words
    wait_done(100, cy);
    chk("t2b_err_timeout", err_timeout, 0);

    // Checker: 0,1,5,3 against 0,1,2,3
    @(posedge clk); #1;
    push(0); push(1); push(5); push(3);
    do_start(4, 8'hFF, 0, 0);
    wait_done(100, cy);
`ifdef FIFO_FWFT_SINK_CHECK_EN
    chk("t3_errd", err_data, 1);  chk("t3_errc", err_count, 1);
`else
    chk("t3_errd", err_data, 0);  chk("t3_errc", err_count, 0);
`endif

    // Zero-length start, then back-to-back start inside the done cycle
    do_start(0, 8'hFF, 0, 0);
    wait_done(10, cy);
    chk("zero_len_cycles", cy, 0);
    chk("zero_len_errd", err_data, 0);
    push(8'h55);
    do_start(1, 8'hFF, 0, 8'h55);
    wait_done(20, cy);
    chk("b2b_last", last_data, 8'h55);

    // Throttled block, FIFO empty for 10 cycles, ignored restart while busy
    do_start(8, 8'h80, 0, 8'h40);
    repeat (10) begin @(posedge clk); #1; end
    for (int i = 0; i < 8; i++) push(WIDTH'(8'h40 + i));
    do_start(1, 8'hFF, 0, 0);
    wait_done(2000, cy);
    chk("t5_wc", word_count, 8);
    chk("t5_last", last_data, 8'h47);
    chk("t5_err_timeout", err_timeout, 0);

    // Reset mid-block after two words
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) push(WIDTH'(8'h30 + i));
    do_start(6, 8'hFF, 0, 8'h30);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0); chk("arst_rden", fif.rden, 0);
    chk("arst_wc", word_count, 0); chk("arst_last", last_data, 0);
    chk("arst_done", done, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    push(8'h36); push(8'h37);
    do_start(6, 8'hFF, 0, 8'h32);
    wait_done(100, cy);
    chk("t6_wc", word_count, 6);
    chk("t6_last", last_data, 8'h37);

    // Randomized blocks with trickled data
    for (int it = 0; it < 30; it++) begin
      int len, rt, tmo, base;
      while (pend.size() != 0) push(pend.pop_front());
      len  = $urandom_range(1, 20);
      rt   = ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(32, 254);
      tmo  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(3, 30);
      base = $urandom_range(0, 255);
      for (int i = 0; i < len; i++) begin
        logic [WIDTH-1:0] w;
        w = ($urandom_range(0, 7) == 0) ? WIDTH'($urandom_range(0, 255)) : WIDTH'(base + i);
        if (i < len / 2) push(w); else pend.push_back(w);
      end
      do_start(len, rt, tmo, base);
      wait_done(20000, cy);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
